// File: rtl/uart_8bytes_pkg.sv
// Shared types and sizes for the 8-byte frame UART receiver.
// Imported by the byte receiver and the frame assembler.
package uart_8bytes_pkg;

  localparam int FRAME_BYTES = 8;
  localparam int DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampled 8N1 character receiver with input synchronizer.
// Strobes are decodes of the stop-sample cycle.
module uart_rx_byte
  import uart_8bytes_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output state_t               state,
  output logic                 start,
  output logic [DATA_BITS-1:0] data,
  output logic                 byte_valid,
  output logic                 stop_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic                 r1;
  logic                 rxs;
  logic                 rxs_d;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 fall;
  logic                 stop_tick;

  assign fall       = rxs_d & ~rxs;
  assign start      = (state == IDLE) & fall;
  assign stop_tick  = (state == STOP) & (cnt == FULL);
  assign byte_valid = stop_tick & rxs;
  assign stop_err   = stop_tick & ~rxs;
  assign data       = shreg;

  // two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      r1    <= rx;
      rxs   <= r1;
      rxs_d <= rxs;
    end
  end

  // character FSM: start qualification, data shift, stop check
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt    <= '0;
            bitcnt <= '0;
            state  <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt    <= '0;
            shreg  <= {rxs, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= rxs ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_8bytes_rx.sv
// Assembles eight received characters into one 64-bit frame.
// Partial frames are dropped on a bad stop bit or idle timeout.
module uart_8bytes_rx
  import uart_8bytes_pkg::*;
#(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rx,
  output logic [FRAME_BYTES*DATA_BITS-1:0] frame,
  output logic                             frame_valid,
  output logic                             frame_err,
  output logic                             timeout,
  output logic                             busy
);

  localparam int LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int IW    = $clog2(LIMIT);
  localparam int XW    = $clog2(FRAME_BYTES);
  localparam logic [IW-1:0] ILAST = IW'(LIMIT - 1);
  localparam logic [XW-1:0] XLAST = XW'(FRAME_BYTES - 1);

  state_t                                 state;
  logic                                   start;
  logic [DATA_BITS-1:0]                   data;
  logic                                   byte_valid;
  logic                                   stop_err;
  logic [XW-1:0]                          idx;
  logic [IW-1:0]                          idle_cnt;
  logic [FRAME_BYTES-2:0][DATA_BITS-1:0]  shadow;

  uart_rx_byte #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .state     (state),
    .start     (start),
    .data      (data),
    .byte_valid(byte_valid),
    .stop_err  (stop_err)
  );

  assign busy = (state != IDLE) || (idx != '0);

  // byte slotting, frame publish, error drop and idle timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      idle_cnt    <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      if (byte_valid) begin
        if (idx == XLAST) begin
          frame       <= {data, shadow};
          frame_valid <= 1'b1;
        end else begin
          for (int k = 0; k < FRAME_BYTES - 1; k++) begin
            if (idx == XW'(k)) begin
              shadow[k] <= data;
            end
          end
        end
        idx <= idx + 1'b1;
      end else if (stop_err) begin
        frame_err <= 1'b1;
        idx       <= '0;
      end else if ((state == IDLE) && (idx != '0)) begin
        if (idle_cnt == ILAST) begin
          timeout  <= 1'b1;
          idx      <= '0;
          idle_cnt <= '0;
        end else if (start) begin
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else if (start) begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/uart_8bytes_rx.md
UART_8BYTES_RX -- requirements
Module: uart_8bytes_rx

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, meaning clk cycles per bit; it SHALL be even and at least 4.
REQ-002 The block SHALL have parameter TIMEOUT_BITS, default 20, meaning idle bit-times allowed between bytes of one frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line from the RS485 receiver, idle high.
REQ-006 The block SHALL have port frame, output, 64 bits: last complete frame; byte k is frame[8k+7:8k], and byte 0 is the first received.
REQ-007 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse marking a new frame.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a partial-frame abort.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever a byte is in reception or a partial frame is held.

Function
REQ-011 rx SHALL pass through a 2-FF synchronizer whose flops reset to 1; all logic SHALL use the synchronized value rxs.
REQ-012 Character format SHALL be: start 0, 8 data bits LSB first, stop 1, no parity; stop may be followed by any idle length.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-014 In IDLE, rxs falling (prev 1, now 1->0) SHALL enter START with the bit counter cleared.
REQ-015 START SHALL sample at count OVERSAMPLE/2-1; a sample of 1 SHALL return to IDLE without error (glitch), and a sample of 0 SHALL enter DATA.
REQ-016 DATA SHALL sample every OVERSAMPLE clocks, shift each bit into the byte register at the MSB end (LSB-first order), and enter STOP after 8 samples.
REQ-017 STOP SHALL sample once after OVERSAMPLE clocks.
REQ-018 A stop sample of 1 SHALL write the byte to shadow slot idx and increment idx (3 bits, wrap 7->0), then return to IDLE.
REQ-019 When a stop sample of 1 is taken with idx=7, shadow plus the last byte SHALL be copied to frame and frame_valid SHALL pulse; both SHALL be visible in the cycle after the stop-sample edge.
REQ-020 A stop sample of 0 SHALL pulse frame_err, clear idx, discard the partial frame, and enter BREAK.
REQ-021 BREAK SHALL wait for rxs=1 before entering IDLE.
REQ-022 frame SHALL hold its value until the next complete frame; partial frames SHALL never alter frame.
REQ-023 In IDLE with idx!=0, an idle counter SHALL count clocks.
REQ-024 Reaching TIMEOUT_BITS*OVERSAMPLE idle clocks SHALL pulse timeout and clear idx.
REQ-025 The idle counter SHALL clear on entering START.
REQ-026 If a timeout and a falling edge occur in the same cycle, the timeout SHALL apply and the new character SHALL be received as byte 0.
REQ-027 frame_err, timeout and frame_valid SHALL be mutually exclusive in any cycle, except the timeout/err case, which is impossible by construction.
REQ-028 Counter widths SHALL be $clog2 of their terminal value; there SHALL be no overflow at parameter extremes.

Reset
REQ-029 While reset is high at a clk edge, the FSM SHALL go to IDLE, idx and all counters SHALL become 0, and the synchronizer SHALL become 1.
REQ-030 While reset is high at a clk edge, frame SHALL become 0, and frame_valid, frame_err, timeout and busy SHALL become 0.
REQ-031 Reset mid-byte or mid-frame SHALL discard all partial data with no pulse output.
REQ-032 Reception SHALL restart only on a falling edge seen after reset deasserts.

Structure
REQ-033 Package uart_8bytes_pkg SHALL hold the FSM state enum, FRAME_BYTES=8 and DATA_BITS=8.
REQ-034 Sub-module uart_rx_byte (synchronizer, FSM, byte deserializer, byte_valid/stop_err strobes) SHALL be instantiated once.
REQ-035 Frame assembly, the shadow buffer and the timeout SHALL live in uart_8bytes_rx.

Verification (OVERSAMPLE=16, TIMEOUT_BITS=20)
REQ-036 Bench SHALL cover: 8 bytes 0x01..0x08 with 2-bit stop gaps -> one frame_valid, frame=64'h0807060504030201, no err.
REQ-037 Bench SHALL cover: 3-clock low glitch on idle rx -> no state beyond START, busy returns 0, no pulses.
REQ-038 Bench SHALL cover: byte 4 sent with stop=0 -> frame_err pulse, frame unchanged; the following 8 good bytes 0xA0..0xA7 -> frame=64'hA7A6A5A4A3A2A1A0.
REQ-039 Bench SHALL cover: 5 bytes then idle 320 clocks -> timeout pulse exactly at clock 320 of idle, busy=0; the next 8 bytes -> a correct frame.
REQ-040 Bench SHALL cover: reset asserted during bit 5 of byte 6 -> all outputs 0 next cycle; the next full frame is received correctly.
REQ-041 Bench SHALL cover: back-to-back frames with 1-bit idle between characters -> two frame_valid pulses, the second frame overwrites the first.
